// File: rtl/core_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// core_sequencer_pkg
//   Shared definitions for the RV32I multi-cycle control sequencer:
//   sequencer state encoding, trap cause codes, RV32I major opcodes and a
//   helper that recognises the opcodes the sequencer knows how to execute.
//   No ports (package).
// ---------------------------------------------------------------------------
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_FETCH = 3'd1,
        S_EX    = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5,
        S_TRAP  = 3'd6
    } seqstate_t;

    localparam logic [1:0] TRAP_ILLEGAL   = 2'd0;
    localparam logic [1:0] TRAP_MISALIGN  = 2'd1;
    localparam logic [1:0] TRAP_IFETCH_TO = 2'd2;
    localparam logic [1:0] TRAP_DATA_TO   = 2'd3;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // addi x0, x0, 0 -- the instruction register holds a NOP out of reset
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    function automatic logic is_rv32i_op(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_IMM, OP_REG: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// ---------------------------------------------------------------------------
// seq_watchdog
//   Request timeout down-counter shared by the fetch and data ports.
//   The counter reloads to TIMEOUT while clr is high and counts down by one
//   for every cycle en is high. expire fires in the TIMEOUT-th waiting cycle,
//   i.e. the last cycle in which a response would still have been accepted.
//   TIMEOUT = 0 disables expiry.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     en        : a request is outstanding and no response this cycle
//     clr       : no request outstanding; reload the counter
//     expire    : timeout reached this cycle
// ---------------------------------------------------------------------------
module seq_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = W'(TIMEOUT);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= W'(TIMEOUT);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (TIMEOUT != 0) && en && !clr && (cnt_q == W'(1));

endmodule

// File: rtl/core_sequencer.sv
// ---------------------------------------------------------------------------
// core_sequencer
//   Multi-cycle control sequencer for the RV32I core. Owns the PC and the
//   INIT/FETCH/EX/MEM/WB state machine, drives the instruction and data
//   request ports (level-held until valid, guarded by a timeout watchdog),
//   stages the regfile write-back, records sticky traps and provides
//   halt/single-step debug control and a retired-instruction counter.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     instr_req/addr/valid/rdata : instruction fetch port
//     instruction              : latched instruction word to the decoder
//     dec_op/func/imm/oplen    : decoded fields (combinational from decoder)
//     alu_result, rs2_data     : ALU output and store data
//     data_req/we/addr/wdata/oplen/unsigned, data_valid/rdata : data port
//     rf_we, rf_wdata          : regfile write-back (one-cycle pulse in WB)
//     pc                       : current program counter
//     halt_req, step_req, halted : debug control/status
//     trap, trap_cause, trap_pc  : sticky trap status
//     retired                  : retired-instruction count
// ---------------------------------------------------------------------------
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INIT_CYCLES  = 33,
    parameter int              MEM_TIMEOUT  = 255,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,

    output logic             instr_req,
    output logic [XLEN-1:0]  instr_addr,
    input  logic             instr_valid,
    input  logic [31:0]      instr_rdata,
    output logic [31:0]      instruction,

    input  logic [6:0]       dec_op,
    input  logic [9:0]       dec_func,
    input  logic [XLEN-1:0]  dec_imm,
    input  logic [1:0]       dec_oplen,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  rs2_data,

    output logic             data_req,
    output logic             data_we,
    output logic [XLEN-1:0]  data_addr,
    output logic [XLEN-1:0]  data_wdata,
    output logic [1:0]       data_oplen,
    output logic             data_unsigned,
    input  logic             data_valid,
    input  logic [XLEN-1:0]  data_rdata,

    output logic             rf_we,
    output logic [XLEN-1:0]  rf_wdata,
    output logic [XLEN-1:0]  pc,

    input  logic             halt_req,
    input  logic             step_req,
    output logic             halted,

    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [XLEN-1:0]  trap_pc,
    output logic [CNT_W-1:0] retired
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam int WD_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    seqstate_t        state_q,         state_d;
    logic [INIT_W-1:0] init_cnt_q,     init_cnt_d;
    logic [XLEN-1:0]  pc_q,            pc_d;
    logic [31:0]      instruction_q,   instruction_d;
    logic             instr_req_q,     instr_req_d;
    logic             data_req_q,      data_req_d;
    logic             data_we_q,       data_we_d;
    logic [XLEN-1:0]  data_addr_q,     data_addr_d;
    logic [XLEN-1:0]  data_wdata_q,    data_wdata_d;
    logic [1:0]       data_oplen_q,    data_oplen_d;
    logic             data_unsigned_q, data_unsigned_d;
    logic [XLEN-1:0]  wb_data_q,       wb_data_d;
    logic             wb_en_q,         wb_en_d;
    logic [XLEN-1:0]  nextpc_q,        nextpc_d;
    logic [CNT_W-1:0] retired_q,       retired_d;
    logic             step_q,          step_d;
    logic             trap_q,          trap_d;
    logic [1:0]       trap_cause_q,    trap_cause_d;
    logic [XLEN-1:0]  trap_pc_q,       trap_pc_d;

    logic             take_trap;
    logic [1:0]       cause_n;

    logic             is_load, is_store, is_jal, is_jalr, is_branch, br_taken;
    logic [XLEN-1:0]  pc_plus4, pc_plus_imm;

    logic             wd_en, wd_clr, wd_expire;

    // Only funct3[2] (load sign) and funct3[0] (branch sense) matter here.
    logic             unused_func;
    assign unused_func = ^{dec_func[9:3], dec_func[1]};

    assign is_load     = (dec_op == OP_LOAD);
    assign is_store    = (dec_op == OP_STORE);
    assign is_jal      = (dec_op == OP_JAL);
    assign is_jalr     = (dec_op == OP_JALR);
    assign is_branch   = (dec_op == OP_BRANCH);
    // ALU reports the compare result in bit 0; funct3[0] inverts the sense
    // (BEQ/BNE, BLT/BGE, BLTU/BGEU).
    assign br_taken    = (alu_result[0] != dec_func[0]);
    assign pc_plus4    = pc_q + XLEN'(4);
    assign pc_plus_imm = pc_q + dec_imm;

    // One watchdog serves both ports: fetch and data requests are never
    // outstanding at the same time, and every request is preceded by at
    // least one request-free cycle that reloads the counter.
    assign wd_en  = (instr_req_q && !instr_valid) || (data_req_q && !data_valid);
    assign wd_clr = !(instr_req_q || data_req_q);

    seq_watchdog #(
        .TIMEOUT (MEM_TIMEOUT),
        .W       (WD_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .en     (wd_en),
        .clr    (wd_clr),
        .expire (wd_expire)
    );

    always_comb begin
        state_d         = state_q;
        init_cnt_d      = init_cnt_q;
        pc_d            = pc_q;
        instruction_d   = instruction_q;
        instr_req_d     = instr_req_q;
        data_req_d      = data_req_q;
        data_we_d       = data_we_q;
        data_addr_d     = data_addr_q;
        data_wdata_d    = data_wdata_q;
        data_oplen_d    = data_oplen_q;
        data_unsigned_d = data_unsigned_q;
        wb_data_d       = wb_data_q;
        wb_en_d         = wb_en_q;
        nextpc_d        = nextpc_q;
        retired_d       = retired_q;
        step_d          = step_q;
        trap_d          = trap_q;
        trap_cause_d    = trap_cause_q;
        trap_pc_d       = trap_pc_q;
        take_trap       = 1'b0;
        cause_n         = TRAP_ILLEGAL;

        case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d     = S_FETCH;
                    instr_req_d = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end

            S_FETCH: begin
                if (instr_req_q && instr_valid) begin
                    instruction_d = instr_rdata;
                    instr_req_d   = 1'b0;
                    state_d       = S_EX;
                end else if (wd_expire) begin
                    take_trap = 1'b1;
                    cause_n   = TRAP_IFETCH_TO;
                end
            end

            S_EX: begin
                if (!is_rv32i_op(dec_op)) begin
                    take_trap = 1'b1;
                    cause_n   = TRAP_ILLEGAL;
                end else begin
                    if (is_load || is_store) begin
                        data_req_d      = 1'b1;
                        data_we_d       = is_store;
                        data_addr_d     = alu_result;
                        data_wdata_d    = rs2_data;
                        data_oplen_d    = dec_oplen;
                        data_unsigned_d = dec_func[2];
                    end
                    wb_data_d = (is_jal || is_jalr) ? pc_plus4 : alu_result;
                    wb_en_d   = !(is_store || is_branch);
                    if (is_jalr) begin
                        nextpc_d = {alu_result[XLEN-1:1], 1'b0};
                    end else if (is_jal || (is_branch && br_taken)) begin
                        nextpc_d = pc_plus_imm;
                    end else begin
                        nextpc_d = pc_plus4;
                    end
                    state_d = S_MEM;
                end
            end

            S_MEM: begin
                if (data_req_q) begin
                    if (data_valid) begin
                        data_req_d = 1'b0;
                        // data_we_q low here means the access is a load
                        if (!data_we_q) begin
                            wb_data_d = data_rdata;
                        end
                        state_d = S_WB;
                    end else if (wd_expire) begin
                        take_trap = 1'b1;
                        cause_n   = TRAP_DATA_TO;
                    end
                end else begin
                    state_d = S_WB;
                end
            end

            S_WB: begin
                if (nextpc_q[1:0] != 2'b00) begin
                    take_trap = 1'b1;
                    cause_n   = TRAP_MISALIGN;
                end else begin
                    pc_d      = nextpc_q;
                    retired_d = retired_q + CNT_W'(1);
                    if (halt_req || step_q) begin
                        state_d = S_HALT;
                        step_d  = 1'b0;
                    end else begin
                        state_d     = S_FETCH;
                        instr_req_d = 1'b1;
                    end
                end
            end

            S_HALT: begin
                // Releasing halt takes priority over a coincident step pulse.
                if (!halt_req) begin
                    state_d     = S_FETCH;
                    instr_req_d = 1'b1;
                end else if (step_req) begin
                    state_d     = S_FETCH;
                    instr_req_d = 1'b1;
                    step_d      = 1'b1;
                end
            end

            S_TRAP: begin
                state_d = S_TRAP;
            end

            default: begin
                state_d = S_TRAP;
            end
        endcase

        if (take_trap) begin
            state_d      = S_TRAP;
            trap_d       = 1'b1;
            trap_cause_d = cause_n;
            trap_pc_d    = pc_q;
            instr_req_d  = 1'b0;
            data_req_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_INIT;
            init_cnt_q      <= '0;
            pc_q            <= RESET_VECTOR;
            instruction_q   <= NOP_INSTR;
            instr_req_q     <= 1'b0;
            data_req_q      <= 1'b0;
            data_we_q       <= 1'b0;
            data_addr_q     <= '0;
            data_wdata_q    <= '0;
            data_oplen_q    <= '0;
            data_unsigned_q <= 1'b0;
            wb_data_q       <= '0;
            retired_q       <= '0;
            step_q          <= 1'b0;
            trap_q          <= 1'b0;
            trap_cause_q    <= '0;
            trap_pc_q       <= '0;
        end else begin
            state_q         <= state_d;
            init_cnt_q      <= init_cnt_d;
            pc_q            <= pc_d;
            instruction_q   <= instruction_d;
            instr_req_q     <= instr_req_d;
            data_req_q      <= data_req_d;
            data_we_q       <= data_we_d;
            data_addr_q     <= data_addr_d;
            data_wdata_q    <= data_wdata_d;
            data_oplen_q    <= data_oplen_d;
            data_unsigned_q <= data_unsigned_d;
            wb_data_q       <= wb_data_d;
            retired_q       <= retired_d;
            step_q          <= step_d;
            trap_q          <= trap_d;
            trap_cause_q    <= trap_cause_d;
            trap_pc_q       <= trap_pc_d;
        end
    end

    // Staged EX results; only observed in WB after EX has written them.
    always_ff @(posedge clk) begin
        nextpc_q <= nextpc_d;
        wb_en_q  <= wb_en_d;
    end

    assign instr_req     = instr_req_q;
    assign instr_addr    = pc_q;
    assign instruction   = instruction_q;
    assign data_req      = data_req_q;
    assign data_we       = data_we_q;
    assign data_addr     = data_addr_q;
    assign data_wdata    = data_wdata_q;
    assign data_oplen    = data_oplen_q;
    assign data_unsigned = data_unsigned_q;
    // A misaligned target suppresses the write together with the PC update.
    assign rf_we         = (state_q == S_WB) && wb_en_q && (nextpc_q[1:0] == 2'b00);
    assign rf_wdata      = wb_data_q;
    assign pc            = pc_q;
    assign halted        = (state_q == S_HALT);
    assign trap          = trap_q;
    assign trap_cause    = trap_cause_q;
    assign trap_pc       = trap_pc_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// ---------------------------------------------------------------------------
// tb_core_sequencer
//   Directed bench for core_sequencer. The bench plays memory and decoder:
//   it answers fetches after a chosen latency and presents the decoded
//   fields / ALU result for each instruction. Inputs are driven and outputs
//   sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_core_sequencer;

    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_IMM    = 7'b0010011;
    localparam logic [6:0] T_BAD    = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_rdata = '0;
    logic [31:0] instruction;
    logic [6:0]  dec_op = '0;
    logic [9:0]  dec_func = '0;
    logic [31:0] dec_imm = '0;
    logic [1:0]  dec_oplen = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] rs2_data = '0;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [1:0]  data_oplen;
    logic        data_unsigned;
    logic        data_valid = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic        halt_req = 1'b0;
    logic        step_req = 1'b0;
    logic        halted;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] retired;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    core_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (32'h100),
        .INIT_CYCLES  (4),
        .MEM_TIMEOUT  (8),
        .CNT_W        (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_req     (instr_req),
        .instr_addr    (instr_addr),
        .instr_valid   (instr_valid),
        .instr_rdata   (instr_rdata),
        .instruction   (instruction),
        .dec_op        (dec_op),
        .dec_func      (dec_func),
        .dec_imm       (dec_imm),
        .dec_oplen     (dec_oplen),
        .alu_result    (alu_result),
        .rs2_data      (rs2_data),
        .data_req      (data_req),
        .data_we       (data_we),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_oplen    (data_oplen),
        .data_unsigned (data_unsigned),
        .data_valid    (data_valid),
        .data_rdata    (data_rdata),
        .rf_we         (rf_we),
        .rf_wdata      (rf_wdata),
        .pc            (pc),
        .halt_req      (halt_req),
        .step_req      (step_req),
        .halted        (halted),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .trap_pc       (trap_pc),
        .retired       (retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset for two cycles, check reset state, release.
    task automatic do_reset();
        rst         = 1'b1;
        instr_valid = 1'b0;
        data_valid  = 1'b0;
        halt_req    = 1'b0;
        step_req    = 1'b0;
        tick(2);
        chk("rst_pc",        pc,                    32'h100);
        chk("rst_iaddr",     instr_addr,            32'h100);
        chk("rst_instr",     instruction,           32'h00000013);
        chk("rst_ireq",      32'(instr_req),        0);
        chk("rst_dreq",      32'(data_req),         0);
        chk("rst_trap",      32'(trap),             0);
        chk("rst_retired",   retired,               0);
        chk("rst_halted",    32'(halted),           0);
        rst = 1'b0;
    endtask

    // Called in (or before) the first FETCH cycle: present the decode for
    // this instruction and answer the fetch k cycles later. Returns at the
    // falling edge of the EX cycle.
    task automatic fetch(input int k, input logic [6:0] op, input logic [9:0] func,
                         input logic [31:0] imm, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [1:0] oplen,
                         input logic [31:0] word);
        int w = 0;
        while (!instr_req && w < 20) begin
            tick(1);
            w++;
        end
        chk("fetch_req_seen", 32'(instr_req), 1);
        dec_op      = op;
        dec_func    = func;
        dec_imm     = imm;
        alu_result  = alu;
        rs2_data    = rs2;
        dec_oplen   = oplen;
        instr_rdata = word;
        tick(k);
        instr_valid = 1'b1;
        tick(1);
        instr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running, expected finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // ---- reset and first fetch ----
        do_reset();
        tick(3);
        chk("init_wait", 32'(instr_req), 0);
        tick(1);
        chk("first_fetch_req",  32'(instr_req), 1);
        chk("first_fetch_addr", instr_addr,     32'h100);

        // ---- ADDI x1,x0,5 with k=2 (FETCH entry = cycle 0) ----
        fetch(2, T_IMM, 10'h0, 32'd5, 32'd5, 32'h0, 2'b00, 32'h00500093);
        chk("addi_instr",    instruction,    32'h00500093);
        chk("addi_req_drop", 32'(instr_req), 0);
        tick(1);
        chk("addi_we_mem",   32'(rf_we),     0);
        tick(1);
        chk("addi_we",       32'(rf_we),     1);
        chk("addi_wdata",    rf_wdata,       32'd5);
        chk("addi_pc_in_wb", pc,             32'h100);
        tick(1);
        chk("addi_pc",       pc,             32'h104);
        chk("addi_retired",  retired,        1);
        chk("addi_we_pulse", 32'(rf_we),     0);
        chk("addi_refetch",  32'(instr_req), 1);

        // ---- BEQ taken, imm=-8 ----
        fetch(0, T_BRANCH, 10'h0, 32'hFFFF_FFF8, 32'd1, 32'h0, 2'b00, 32'hFE000CE3);
        tick(2);
        chk("beq_no_we",     32'(rf_we),     0);
        tick(1);
        chk("beq_target",    instr_addr,     32'h0FC);
        chk("beq_retired",   retired,        2);

        // ---- LW, alu=0x40, m=3 ----
        fetch(1, T_LOAD, 10'h2, 32'h0, 32'h40, 32'h0, 2'b10, 32'h04002083);
        chk("lw_req_ex", 32'(data_req), 0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("lw_req_hold", 32'(data_req), 1);
            if (i == 0) begin
                chk("lw_addr",  data_addr,          32'h40);
                chk("lw_we",    32'(data_we),       0);
                chk("lw_oplen", 32'(data_oplen),    2);
                chk("lw_uns",   32'(data_unsigned), 0);
            end
            if (i == 3) begin
                data_valid = 1'b1;
                data_rdata = 32'hDEADBEEF;
            end
        end
        tick(1);
        data_valid = 1'b0;
        chk("lw_req_drop", 32'(data_req), 0);
        chk("lw_we_wb",    32'(rf_we),    1);
        chk("lw_wdata",    rf_wdata,      32'hDEADBEEF);
        tick(1);
        chk("lw_pc",       pc,            32'h100);
        chk("lw_retired",  retired,       3);

        // ---- SW with immediate response (m=0) ----
        fetch(0, T_STORE, 10'h2, 32'h0, 32'h44, 32'h12345678, 2'b10, 32'h04102223);
        tick(1);
        chk("sw_req",   32'(data_req), 1);
        chk("sw_we",    32'(data_we),  1);
        chk("sw_wdata", data_wdata,    32'h12345678);
        data_valid = 1'b1;
        tick(1);
        data_valid = 1'b0;
        chk("sw_req_drop", 32'(data_req), 0);
        chk("sw_no_rf_we", 32'(rf_we),    0);
        tick(1);
        chk("sw_pc",       pc,            32'h104);
        chk("sw_retired",  retired,       4);

        // ---- halt, single step, resume ----
        halt_req = 1'b1;
        fetch(0, T_IMM, 10'h0, 32'd7, 32'd7, 32'h0, 2'b00, 32'h00700093);
        tick(3);
        chk("halt_halted",  32'(halted),    1);
        chk("halt_ireq",    32'(instr_req), 0);
        chk("halt_pc",      pc,             32'h108);
        chk("halt_retired", retired,        5);
        tick(2);
        chk("halt_stays",   32'(halted),    1);
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        chk("step_fetch",   32'(instr_req), 1);
        chk("step_unhalt",  32'(halted),    0);
        fetch(0, T_IMM, 10'h0, 32'd9, 32'd9, 32'h0, 2'b00, 32'h00900093);
        tick(3);
        chk("step_rehalt",  32'(halted),    1);
        chk("step_retired", retired,        6);
        chk("step_pc",      pc,             32'h10C);
        tick(2);
        chk("step_once",    retired,        6);
        halt_req = 1'b0;
        tick(1);
        chk("resume_fetch", 32'(instr_req), 1);
        chk("resume_unhalt", 32'(halted),   0);

        // ---- illegal opcode ----
        fetch(0, T_BAD, 10'h0, 32'h0, 32'h0, 32'h0, 2'b00, 32'hFFFFFFFF);
        tick(1);
        chk("ill_trap",   32'(trap),       1);
        chk("ill_cause",  32'(trap_cause), 0);
        chk("ill_pc",     trap_pc,         32'h10C);
        chk("ill_ireq",   32'(instr_req),  0);
        halt_req = 1'b1;
        tick(2);
        chk("trap_ignores_halt", 32'(halted), 0);
        chk("trap_sticky",       32'(trap),   1);
        halt_req = 1'b0;

        // ---- JAL then misaligned JALR ----
        do_reset();
        tick(4);
        fetch(0, T_JAL, 10'h0, 32'h20, 32'h0, 32'h0, 2'b00, 32'h020000EF);
        tick(2);
        chk("jal_we",      32'(rf_we), 1);
        chk("jal_link",    rf_wdata,   32'h104);
        tick(1);
        chk("jal_pc",      pc,         32'h120);
        chk("jal_retired", retired,    1);
        fetch(0, T_JALR, 10'h0, 32'h0, 32'h203, 32'h0, 2'b00, 32'h203000E7);
        tick(2);
        chk("jalr_no_we",  32'(rf_we),      0);
        tick(1);
        chk("jalr_trap",   32'(trap),       1);
        chk("jalr_cause",  32'(trap_cause), 1);
        chk("jalr_tpc",    trap_pc,         32'h120);
        chk("jalr_pc",     pc,              32'h120);
        chk("jalr_ret",    retired,         1);

        // ---- data watchdog: valid in the 8th cycle wins, then timeout ----
        do_reset();
        tick(4);
        fetch(0, T_LOAD, 10'h2, 32'h0, 32'h80, 32'h0, 2'b10, 32'h08002083);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (i == 7) begin
                chk("wd_edge_req", 32'(data_req), 1);
                data_valid = 1'b1;
                data_rdata = 32'hCAFE0001;
            end
        end
        tick(1);
        data_valid = 1'b0;
        chk("wd_edge_notrap", 32'(trap),  0);
        chk("wd_edge_we",     32'(rf_we), 1);
        chk("wd_edge_wdata",  rf_wdata,   32'hCAFE0001);
        tick(1);
        fetch(0, T_LOAD, 10'h2, 32'h0, 32'h84, 32'h0, 2'b10, 32'h08402083);
        tick(8);
        chk("wd_pre_trap",  32'(trap),       0);
        chk("wd_pre_req",   32'(data_req),   1);
        tick(1);
        chk("wd_trap",      32'(trap),       1);
        chk("wd_cause",     32'(trap_cause), 3);
        chk("wd_tpc",       trap_pc,         32'h104);
        chk("wd_req_drop",  32'(data_req),   0);

        // ---- fetch watchdog ----
        do_reset();
        tick(4);
        tick(7);
        chk("ifwd_pre_trap", 32'(trap),       0);
        chk("ifwd_pre_req",  32'(instr_req),  1);
        tick(1);
        chk("ifwd_trap",     32'(trap),       1);
        chk("ifwd_cause",    32'(trap_cause), 2);
        chk("ifwd_tpc",      trap_pc,         32'h100);
        chk("ifwd_req_drop", 32'(instr_req),  0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
